// File: rtl/serial_word_pkg.sv
// Shared FSM type, defaults and round-robin helper for the serial word arbiter.
// Defining SER_PARITY_EN adds the PARITY state to the FSM encoding.
package serial_word_pkg;

   localparam int WORD_W_DEF = 16;
   localparam int CNT_W      = $clog2(WORD_W_DEF);

`ifdef SER_PARITY_EN
   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP, ST_PARITY} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;
`endif

   // On a tie the requester that was not served last wins; a lone request always wins.
   function automatic logic rr_pick(input logic r0, input logic r1, input logic last_srv);
      return (r0 & r1) ? ~last_srv : r1;
   endfunction

endpackage

// File: rtl/word_shifter.sv
// Load/shift-left word register feeding the serial MSB tap; load beats shift, otherwise hold.
module word_shifter
   import serial_word_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_en,
   input  logic              shift_en,
   input  logic [WORD_W-1:0] load_data,
   output logic              msb
);

   logic [WORD_W-1:0] sreg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sreg <= '0;
      end else if (load_en) begin
         sreg <= load_data;
      end else if (shift_en) begin
         sreg <= {sreg[WORD_W-2:0], 1'b0};
      end
   end

   assign msb = sreg[WORD_W-1];

endmodule

// File: rtl/serial_word_arbiter.sv
// Two-requester round-robin front end that serialises the granted word MSB first.
// Optional feature: define SER_PARITY_EN to append an even-parity bit to every word.
module serial_word_arbiter
   import serial_word_pkg::*;
#(
   parameter int WORD_W     = WORD_W_DEF,
   parameter int GAP_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic [WORD_W-1:0] data0,
   output logic              gnt0,
   input  logic              req1,
   input  logic [WORD_W-1:0] data1,
   output logic              gnt1,
   output logic              ser_out,
   output logic              ser_valid,
   output logic              ser_last,
   output logic              busy,
   output logic              owner
);

   localparam int            CW        = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [CW-1:0] LAST_BIT  = CW'(WORD_W - 1);
   localparam logic [CW-1:0] NEXT_LAST = CW'(WORD_W - 2);
   localparam logic [3:0]    GAP_END   = 4'(GAP_CYCLES - 1);
   localparam state_t        POST_WORD = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
   localparam logic          POST_BUSY = (GAP_CYCLES != 0);
`ifdef SER_PARITY_EN
   localparam logic          PAR_EN    = 1'b1;
`else
   localparam logic          PAR_EN    = 1'b0;
`endif

   state_t        state;
   logic [CW-1:0] bit_cnt;
   logic [3:0]    gap_cnt;
   logic          last_srv;
   logic          win;
   logic          any_req;
   logic          load_en;
   logic          shift_en;
   logic          msb;
   logic [WORD_W-1:0] win_data;

   assign any_req  = req0 | req1;
   assign win      = rr_pick(req0, req1, last_srv);
   assign win_data = win ? data1 : data0;
   assign load_en  = (state == ST_IDLE) && any_req;
   assign shift_en = (state == ST_SHIFT);

   word_shifter #(.WORD_W(WORD_W)) u_shifter (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_en  (load_en),
      .shift_en (shift_en),
      .load_data(win_data),
      .msb      (msb)
   );

`ifdef SER_PARITY_EN
   logic par_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         par_q <= 1'b0;
      end else if (load_en) begin
         par_q <= ^win_data;
      end
   end

   // The register has shifted out to zero by PARITY, so OR-ing in the parity flop is safe.
   assign ser_out = msb | ((state == ST_PARITY) & par_q);
`else
   assign ser_out = msb;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         gap_cnt   <= '0;
         last_srv  <= 1'b1;
         owner     <= 1'b0;
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         ser_valid <= 1'b0;
         ser_last  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         gnt0 <= 1'b0;
         gnt1 <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  state     <= ST_SHIFT;
                  owner     <= win;
                  last_srv  <= win;
                  bit_cnt   <= '0;
                  gnt0      <= ~win;
                  gnt1      <= win;
                  ser_valid <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            ST_SHIFT: begin
               bit_cnt <= bit_cnt + 1'b1;
               if (bit_cnt == LAST_BIT) begin
`ifdef SER_PARITY_EN
                  state    <= ST_PARITY;
                  ser_last <= 1'b1;
`else
                  state     <= POST_WORD;
                  busy      <= POST_BUSY;
                  gap_cnt   <= '0;
                  ser_valid <= 1'b0;
                  ser_last  <= 1'b0;
`endif
               end else begin
                  // Registered, so raised one edge ahead of the bit it marks.
                  ser_last <= (bit_cnt == NEXT_LAST) && !PAR_EN;
               end
            end
`ifdef SER_PARITY_EN
            ST_PARITY: begin
               state     <= POST_WORD;
               busy      <= POST_BUSY;
               gap_cnt   <= '0;
               ser_valid <= 1'b0;
               ser_last  <= 1'b0;
            end
`endif
            ST_GAP: begin
               if (gap_cnt == GAP_END) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
